// File: rtl/fir_serial_pkg.sv
// fir_serial_pkg: shared state encodings and sizing helpers for the FIR serial host bridge.
package fir_serial_pkg;
  localparam int DEFAULT_DATA_WIDTH = 24;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_RELEASE} rx_state_t;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fir_serial_host_if.sv
// fir_serial_host_if: parallel word and serial filter handshake signals of the host bridge.
interface fir_serial_host_if
  import fir_serial_pkg::*;
#(parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH);
  logic [DATA_WIDTH-1:0] i_word;
  logic                  i_word_valid;
  logic                  o_word_ready;
  logic                  o_din;
  logic                  o_din_valid;
  logic                  i_fir_ready;
  logic                  i_dout;
  logic                  i_dout_valid;
  logic                  o_fir_ready;
  logic [DATA_WIDTH-1:0] o_word;
  logic                  o_word_valid;
  modport slave (
    input  i_word, i_word_valid, i_fir_ready, i_dout, i_dout_valid,
    output o_word_ready, o_din, o_din_valid, o_fir_ready, o_word, o_word_valid
  );
  modport master (
    output i_word, i_word_valid, i_fir_ready, i_dout, i_dout_valid,
    input  o_word_ready, o_din, o_din_valid, o_fir_ready, o_word, o_word_valid
  );
endinterface

// File: rtl/fir_serial_rx.sv
// fir_serial_rx: deserializes the filter's LSB-first output stream into parallel words.
module fir_serial_rx
  import fir_serial_pkg::*;
#(parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_dout,
  input  logic                  i_dout_valid,
  output logic                  o_fir_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  rx_state_t             r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  always_comb begin
    w_next = (r_state == RX_IDLE && i_dout_valid) ? RX_CAPTURE :
             (r_state == RX_CAPTURE && r_cnt == LAST) ? RX_RELEASE :
             (r_state == RX_RELEASE) ? RX_IDLE : r_state;
  end
  // partial words live in r_data so an aborted capture never reaches o_word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_data       <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else if (i_en) begin
      r_state      <= w_next;
      r_cnt        <= (r_state == RX_CAPTURE) ? r_cnt + 1'b1 : '0;
      o_word_valid <= (r_state == RX_RELEASE);
      if (r_state == RX_CAPTURE) r_data[r_cnt] <= i_dout;
      if (r_state == RX_RELEASE) o_word <= r_data;
    end
  end
  assign o_fir_ready = (r_state != RX_IDLE);
endmodule

// File: rtl/fir_serial_host.sv
// fir_serial_host: serializes parallel samples into the FIR filter and deserializes its output.
module fir_serial_host
  import fir_serial_pkg::*;
#(parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  fir_serial_host_if.slave bus
);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  tx_state_t             r_tx_state, w_tx_next;
  logic [CW-1:0]         r_tx_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic                  r_rst_hold;
  always_comb begin
    w_tx_next = (r_tx_state == TX_IDLE && bus.i_word_valid) ? TX_REQ :
                (r_tx_state == TX_REQ && bus.i_fir_ready) ? TX_SHIFT :
                (r_tx_state == TX_SHIFT && r_tx_cnt == LAST) ? TX_IDLE : r_tx_state;
  end
  // r_rst_hold keeps o_word_ready low while reset is applied
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_sh    <= '0;
      r_rst_hold <= 1'b1;
    end else if (i_en) begin
      r_tx_state <= w_tx_next;
      r_rst_hold <= 1'b0;
      r_tx_cnt   <= (r_tx_state == TX_SHIFT) ? r_tx_cnt + 1'b1 : '0;
      if (r_tx_state == TX_IDLE && bus.i_word_valid) r_tx_sh <= bus.i_word;
      if (r_tx_state == TX_SHIFT) r_tx_sh <= r_tx_sh >> 1;
    end
  end
  assign bus.o_word_ready = (r_tx_state == TX_IDLE) && !r_rst_hold;
  assign bus.o_din_valid  = (r_tx_state != TX_IDLE);
  assign bus.o_din        = (r_tx_state == TX_SHIFT) && r_tx_sh[0];
  fir_serial_rx #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_dout       (bus.i_dout),
    .i_dout_valid (bus.i_dout_valid),
    .o_fir_ready  (bus.o_fir_ready),
    .o_word       (bus.o_word),
    .o_word_valid (bus.o_word_valid)
  );
endmodule

// File: doc/fir_serial_host.md
# fir_serial_host

Host-side bridge for the FIR filter's serial sample link: accepts parallel samples, serializes them LSB-first into the filter's `i_din`/`i_din_valid`/`o_ready` input handshake, and deserializes the filter's `o_dout`/`o_dout_valid`/`i_ready` output stream back into parallel words. It sits between a parallel sample source/sink (audio front end, DMA) and `top_level`, replacing bench-driven serialization in the synthesized system.

## Interface
Parameters:
- `DATA_WIDTH`, 24, sample width in bits (≥2)

Ports:
- `i_clk`  in  1  single clock, all logic on rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_en`  in  1  global enable; low freezes both FSMs, counters and outputs
- `i_word`  in  DATA_WIDTH  parallel sample to send
- `i_word_valid`  in  1  `i_word` valid
- `o_word_ready`  out  1  TX idle, can accept `i_word`
- `o_din`  out  1  serial bit to filter `i_din`
- `o_din_valid`  out  1  to filter `i_din_valid`
- `i_fir_ready`  in  1  from filter `o_ready`
- `i_dout`  in  1  serial bit from filter `o_dout`
- `i_dout_valid`  in  1  from filter `o_dout_valid`
- `o_fir_ready`  out  1  to filter `i_ready`
- `o_word`  out  DATA_WIDTH  deserialized filter output
- `o_word_valid`  out  1  one-cycle pulse, `o_word` new

## Operation
- TX FSM: `TX_IDLE` → `TX_REQ` → `TX_SHIFT` → `TX_IDLE`.
  - `TX_IDLE`: `o_word_ready`=1, `o_din_valid`=0. Edge with `i_word_valid`=1 captures `i_word` into shift reg → `TX_REQ`.
  - `TX_REQ`: `o_word_ready`=0, `o_din_valid`=1, `o_din`=0. Edge with `i_fir_ready`=1 → `TX_SHIFT`, bit counter=0.
  - `TX_SHIFT`: `o_din_valid`=1, `o_din`=shreg[0]; each edge shifts right, counter++. After edge where counter=DATA_WIDTH-1 → `TX_IDLE`.
- RX FSM: `RX_IDLE` → `RX_CAPTURE` → `RX_RELEASE` → `RX_IDLE`.
  - `RX_IDLE`: `o_fir_ready`=0. Edge with `i_dout_valid`=1 → `RX_CAPTURE`, counter=0.
  - `RX_CAPTURE`: `o_fir_ready`=1; each edge samples `i_dout` into bit[counter] (LSB first), counter++. After DATA_WIDTH samples → `RX_RELEASE`.
  - `RX_RELEASE`: `o_fir_ready`=1, no sample; next edge → `RX_IDLE`, `o_word` loaded, `o_word_valid`=1 for that one cycle.
- TX and RX fully independent; full duplex allowed.
- `i_dout_valid` ignored outside `RX_IDLE`; `i_word_valid` ignored outside `TX_IDLE`.
- `i_en`=0: no state, counter, shift or output register changes; `o_word_valid` pulse, if registered high, held until `i_en` returns.

## Timing
- Reset (sync, edge with `i_rst`=1): both FSMs idle, counters 0, `o_din`=0, `o_din_valid`=0, `o_fir_ready`=0, `o_word`=0, `o_word_valid`=0, `o_word_ready`=0 while `i_rst`=1; `o_word_ready`=1 first cycle after release.
- Reset mid-transfer aborts immediately; partial TX word dropped, partial RX word discarded (`o_word` keeps 0, no pulse).
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- TX latency: word accepted edge k; `o_din_valid`=1 from k; if `i_fir_ready`=1 at k+1, bit0 on `o_din` k+1..k+2, last bit ends after edge k+DATA_WIDTH+1; `o_word_ready`=1 again after that edge. Minimum TX period DATA_WIDTH+2 cycles.
- RX latency: `i_dout_valid` seen edge m; `o_fir_ready`=1 after m for DATA_WIDTH+1 cycles; samples at edges m+1..m+DATA_WIDTH; `o_word_valid` after edge m+DATA_WIDTH+1.
- `i_fir_ready` held low: stay in `TX_REQ` indefinitely, no timeout.

## Structure
- Package `fir_serial_pkg`: `tx_state_t`, `rx_state_t` enums, default `DATA_WIDTH`, counter width `$clog2(DATA_WIDTH)` helper.
- Sub-module `fir_serial_rx` (RX FSM + deserializer); TX FSM inline in `fir_serial_host`.

## Test plan
- TX `i_word`=24'h000001, `i_fir_ready` tied 1 → `o_din` 1 on first bit cycle, 0 for next 23; `o_din_valid` high 25 cycles; `o_word_ready` returns after.
- TX 24'hA5A5A5 with `i_fir_ready` low 10 cycles → `o_din_valid` stays 1, `o_din` 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1,... LSB-first.
- RX: pulse `i_dout_valid`, drive 24'h123456 LSB-first aligned to `o_fir_ready` → `o_word`=24'h123456, single-cycle `o_word_valid`, `o_fir_ready` high exactly 25 cycles.
- `i_rst` asserted at TX bit 12 and RX bit 12 → next cycle all outputs 0, no `o_word_valid`; `o_word_ready`=1 one cycle after release.
- `i_en` low 5 cycles at TX bit 8 → `o_din` holds bit 8 value, resumes at bit 9; serial stream otherwise identical.
- Loop through `top_level` with 220-sample sine (200 Hz @ 44 kHz), full duplex → 220 `o_word_valid` pulses per period, no handshake deadlock.
